// File: rtl/render_pkg.sv
// Shared rendering types: tile corner / triangle vertex arrays, corner
// indices, dispatcher state encoding and a small unsigned-min helper.
// No ports; imported by the tile dispatcher, its interface and sub-modules.
package render_pkg;

  // [k][0] = x, [k][1] = y; corners are integers, vertices are IEEE-754 single.
  typedef logic [3:0][1:0][31:0] corner_arr_t;
  typedef logic [2:0][1:0][31:0] tri_pts_t;

  localparam int unsigned TL = 0;
  localparam int unsigned TR = 1;
  localparam int unsigned BL = 2;
  localparam int unsigned BR = 3;

  // Dispatcher state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLIP     = 2'd1;
  localparam logic [1:0] ST_WAIT_REQ = 2'd2;
  localparam logic [1:0] ST_OFFER    = 2'd3;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tile_dispatcher_if.sv
// Triangle load + tile request/start/received bundle between the loader,
// the tile dispatcher (slave / responder) and the pixel processor (master).
// Ports: none; signals are grouped through the master and slave modports.
interface tile_dispatcher_if;
  import render_pkg::*;

  // triangle load side
  logic        tri_valid;
  logic        tri_ready;
  logic [31:0] bbox_min_x;
  logic [31:0] bbox_min_y;
  logic [31:0] bbox_max_x;
  logic [31:0] bbox_max_y;
  tri_pts_t    tri_pts_in;

  // tile handshake side
  logic        request;
  logic        start;
  logic        received;
  corner_arr_t corner_valid;
  tri_pts_t    triangle_pts;
  logic        tile_finished;
  logic [15:0] tile_count;

  modport slave (
    input  tri_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y, tri_pts_in,
    input  request, received,
    output tri_ready, start, corner_valid, triangle_pts, tile_finished, tile_count
  );

  modport master (
    output tri_valid, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y, tri_pts_in,
    output request, received,
    input  tri_ready, start, corner_valid, triangle_pts, tile_finished, tile_count
  );

endinterface

// File: rtl/tile_clip.sv
// Far edge of a tile along one axis: min(base + SPAN - 1, limit), combinational.
// Ports: base (tile origin), limit (clipped bbox max), tile_end (inclusive end).
module tile_clip #(
  parameter int unsigned SPAN = 8
) (
  input  logic [31:0] base,
  input  logic [31:0] limit,
  output logic [31:0] tile_end
);

  logic [31:0] raw_end;

  // base never exceeds limit when used, so the sum stays well inside 32 bits
  assign raw_end  = base + 32'(SPAN - 1);
  assign tile_end = (raw_end > limit) ? limit : raw_end;

endmodule

// File: rtl/tile_dispatcher.sv
// Latches one triangle + bbox, clips the bbox to the screen and hands out
// TILE_W x TILE_H tiles row-major over the request/start/received handshake.
// Ports: clk, rst_n (async active-low), bus (tile_dispatcher_if.slave).
module tile_dispatcher
  import render_pkg::*;
#(
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned TILE_H   = 8,
  parameter int unsigned SCREEN_W = 800,
  parameter int unsigned SCREEN_H = 800
) (
  input logic             clk,
  input logic             rst_n,
  tile_dispatcher_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic [31:0] bmin_x_q, bmin_x_d;
  logic [31:0] bmin_y_q, bmin_y_d;
  logic [31:0] bmax_x_q, bmax_x_d;
  logic [31:0] bmax_y_q, bmax_y_d;
  tri_pts_t    pts_q, pts_d;
  logic [31:0] x0_q, x0_d;
  logic [31:0] y0_q, y0_d;
  logic [31:0] x1_q, x1_d;
  logic [31:0] y1_q, y1_d;
  logic        start_q, start_d;
  logic        tri_ready_q, tri_ready_d;
  logic        tile_finished_q, tile_finished_d;
  logic [15:0] tile_count_q, tile_count_d;

  logic [31:0] cmax_x, cmax_y;
  logic [31:0] nx0, ny0, nx1, ny1;
  logic        row_end, last_tile, empty_box;

  assign cmax_x    = min_u32(bmax_x_q, 32'(SCREEN_W - 1));
  assign cmax_y    = min_u32(bmax_y_q, 32'(SCREEN_H - 1));
  assign empty_box = (bmin_x_q > cmax_x) || (bmin_y_q > cmax_y);
  assign row_end   = (x1_q == cmax_x);
  assign last_tile = row_end && (y1_q == cmax_y);

  // Next tile origin: CLIP seeds from the bbox corner; OFFER steps right or
  // wraps to the start of the next row. The far edges share one clip per axis.
  assign nx0 = ((state_q == ST_CLIP) || row_end) ? bmin_x_q : x0_q + 32'(TILE_W);
  assign ny0 = (state_q == ST_CLIP) ? bmin_y_q :
               (row_end ? y0_q + 32'(TILE_H) : y0_q);

  tile_clip #(.SPAN(TILE_W)) u_clip_x (.base(nx0), .limit(cmax_x), .tile_end(nx1));
  tile_clip #(.SPAN(TILE_H)) u_clip_y (.base(ny0), .limit(cmax_y), .tile_end(ny1));

  always_comb begin
    state_d         = state_q;
    bmin_x_d        = bmin_x_q;
    bmin_y_d        = bmin_y_q;
    bmax_x_d        = bmax_x_q;
    bmax_y_d        = bmax_y_q;
    pts_d           = pts_q;
    x0_d            = x0_q;
    y0_d            = y0_q;
    x1_d            = x1_q;
    y1_d            = y1_q;
    start_d         = start_q;
    tri_ready_d     = tri_ready_q;
    tile_finished_d = tile_finished_q;
    tile_count_d    = tile_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.tri_valid) begin
          bmin_x_d    = bus.bbox_min_x;
          bmin_y_d    = bus.bbox_min_y;
          bmax_x_d    = bus.bbox_max_x;
          bmax_y_d    = bus.bbox_max_y;
          pts_d       = bus.tri_pts_in;
          tri_ready_d = 1'b0;
          state_d     = ST_CLIP;
        end
      end

      ST_CLIP: begin
        if (empty_box) begin
          // nothing on screen: no tiles, tile_finished never drops
          tri_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          x0_d            = nx0;
          y0_d            = ny0;
          x1_d            = nx1;
          y1_d            = ny1;
          tile_finished_d = 1'b0;
          tile_count_d    = 16'd0;
          state_d         = ST_WAIT_REQ;
        end
      end

      ST_WAIT_REQ: begin
        if (bus.request) begin
          start_d = 1'b1;
          state_d = ST_OFFER;
        end
      end

      ST_OFFER: begin
        // tile coordinates only move on the received edge, so the corners
        // are stable through the cycle the processor samples them
        if (bus.received) begin
          start_d      = 1'b0;
          tile_count_d = (tile_count_q == 16'hFFFF) ? tile_count_q : tile_count_q + 16'd1;
          if (last_tile) begin
            tile_finished_d = 1'b1;
            tri_ready_d     = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            x0_d    = nx0;
            y0_d    = ny0;
            x1_d    = nx1;
            y1_d    = ny1;
            state_d = ST_WAIT_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      bmin_x_q        <= '0;
      bmin_y_q        <= '0;
      bmax_x_q        <= '0;
      bmax_y_q        <= '0;
      pts_q           <= '0;
      x0_q            <= '0;
      y0_q            <= '0;
      x1_q            <= '0;
      y1_q            <= '0;
      start_q         <= 1'b0;
      tri_ready_q     <= 1'b1;
      tile_finished_q <= 1'b1;
      tile_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      bmin_x_q        <= bmin_x_d;
      bmin_y_q        <= bmin_y_d;
      bmax_x_q        <= bmax_x_d;
      bmax_y_q        <= bmax_y_d;
      pts_q           <= pts_d;
      x0_q            <= x0_d;
      y0_q            <= y0_d;
      x1_q            <= x1_d;
      y1_q            <= y1_d;
      start_q         <= start_d;
      tri_ready_q     <= tri_ready_d;
      tile_finished_q <= tile_finished_d;
      tile_count_q    <= tile_count_d;
    end
  end

  always_comb begin
    bus.corner_valid        = '0;
    bus.corner_valid[TL][0] = x0_q;
    bus.corner_valid[TL][1] = y0_q;
    bus.corner_valid[TR][0] = x1_q;
    bus.corner_valid[TR][1] = y0_q;
    bus.corner_valid[BL][0] = x0_q;
    bus.corner_valid[BL][1] = y1_q;
    bus.corner_valid[BR][0] = x1_q;
    bus.corner_valid[BR][1] = y1_q;
  end

  assign bus.triangle_pts  = pts_q;
  assign bus.start         = start_q;
  assign bus.tri_ready     = tri_ready_q;
  assign bus.tile_finished = tile_finished_q;
  assign bus.tile_count    = tile_count_q;

endmodule
